uart_cmd_decoder: RTL and testbench

//   Consumes the byte stream from the uart receiver (wr/data pulses) and assembles
//   3-byte character commands: column, row, ASCII code. Each valid command produces
//   one write strobe into the text buffer with a linear cell address and char code.

---
 rtl/uart_cmd_decoder.sv | 124 ++++++++++++
 tb/tb_uart_cmd_decoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// Assembles column/row/char byte triples from the uart into text-buffer writes.
// A mid-command idle timeout drops partial commands so framing restarts at a column byte.
module uart_cmd_decoder #(
   parameter int COLS    = 80,
   parameter int ROWS    = 30,
   parameter int ADDR_W  = 12,
   parameter int TIMEOUT = 65535,
   parameter int TO_W    = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_i,
   input  logic [7:0]        data_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [7:0]        char_o,
   output logic              err_o,
   output logic              timeout_o,
   output logic [1:0]        state_o
);

   // Upstream is strobe-only: each cycle with wr_i=1 carries one byte, there is no
   // ready, so every strobed byte is consumed in the state it arrives in.
   typedef enum logic [1:0] {
      S_COL  = 2'd0,
      S_ROW  = 2'd1,
      S_CHAR = 2'd2
   } state_t;

   localparam logic [31:0]     COLS_U = COLS;
   localparam logic [31:0]     ROWS_U = ROWS;
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT - 1);

   state_t              r_state;
   state_t              w_next;
   logic [7:0]          r_col;
   logic [7:0]          r_row;
   logic [TO_W-1:0]     r_to_cnt;
   logic                r_wr_en;
   logic [ADDR_W-1:0]   r_addr;
   logic [7:0]          r_char;
   logic                r_err;
   logic                r_timeout;
   logic                w_cmd_done;
   logic                w_expire;
   logic                w_valid;
   logic [ADDR_W-1:0]   w_lin;

   assign w_valid = (32'(r_col) < COLS_U) && (32'(r_row) < ROWS_U);
   assign w_lin   = ADDR_W'(r_row) * ADDR_W'(COLS) + ADDR_W'(r_col);

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= S_COL;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_cmd_done = 1'b0;
      w_expire   = 1'b0;
      case (r_state)
         S_COL: begin
            if (wr_i) w_next = S_ROW;
         end
         S_ROW: begin
            if (wr_i) begin
               w_next = S_CHAR;
            end else if (r_to_cnt == TO_MAX) begin
               w_next   = S_COL;
               w_expire = 1'b1;
            end
         end
         S_CHAR: begin
            if (wr_i) begin
               w_next     = S_COL;
               w_cmd_done = 1'b1;
            end else if (r_to_cnt == TO_MAX) begin
               w_next   = S_COL;
               w_expire = 1'b1;
            end
         end
         default: w_next = S_COL;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_col     <= '0;
         r_row     <= '0;
         r_to_cnt  <= '0;
         r_wr_en   <= 1'b0;
         r_addr    <= '0;
         r_char    <= '0;
         r_err     <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_wr_en   <= 1'b0;
         r_err     <= 1'b0;
         r_timeout <= w_expire;
         if (wr_i && r_state == S_COL) r_col <= data_i;
         if (wr_i && r_state == S_ROW) r_row <= data_i;
         if (w_cmd_done) begin
            if (w_valid) begin
               r_wr_en <= 1'b1;
               r_addr  <= w_lin;
               r_char  <= data_i;
            end else begin
               r_err   <= 1'b1;
            end
         end
         // Counter only runs while a command is partially received.
         if (wr_i || r_state == S_COL || w_expire) r_to_cnt <= '0;
         else                                      r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

   assign wr_en_o   = r_wr_en;
   assign addr_o    = r_addr;
   assign char_o    = r_char;
   assign err_o     = r_err;
   assign timeout_o = r_timeout;
   assign state_o   = r_state;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: one default-parameter instance and one with a
// short timeout, both fed the same byte stream.
module tb_uart_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr = 1'b0;
  logic [7:0]  data = 8'd0;

  logic        d_wr_en, d_err, d_timeout;
  logic [11:0] d_addr;
  logic [7:0]  d_char;
  logic [1:0]  d_state;
  logic        t_wr_en, t_err, t_timeout;
  logic [11:0] t_addr;
  logic [7:0]  t_char;
  logic [1:0]  t_state;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_cmd_decoder dut_def (
    .clk_i(clk), .rst_i(rst), .wr_i(wr), .data_i(data),
    .wr_en_o(d_wr_en), .addr_o(d_addr), .char_o(d_char),
    .err_o(d_err), .timeout_o(d_timeout), .state_o(d_state)
  );

  uart_cmd_decoder #(.TIMEOUT(100), .TO_W(16)) dut_to (
    .clk_i(clk), .rst_i(rst), .wr_i(wr), .data_i(data),
    .wr_en_o(t_wr_en), .addr_o(t_addr), .char_o(t_char),
    .err_o(t_err), .timeout_o(t_timeout), .state_o(t_state)
  );

  // All tasks are entered and left at a negedge; outputs are sampled there.
  task automatic send_byte(input logic [7:0] b);
    wr = 1'b1; data = b;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_t(input string name, input logic we, input logic [11:0] a,
                       input logic [7:0] c, input logic e, input logic to);
    n_tests++;
    if ({t_wr_en, t_addr, t_char, t_err, t_timeout} !== {we, a, c, e, to}) begin
      n_fail++;
      $display("FAIL %s: got we=%0b addr=%0d char=%0d err=%0b to=%0b, want we=%0b addr=%0d char=%0d err=%0b to=%0b",
               name, t_wr_en, t_addr, t_char, t_err, t_timeout, we, a, c, e, to);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    n_tests++;
    if ({d_wr_en, d_addr, d_char, d_err, d_timeout, d_state} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_def: got we=%0b addr=%0d char=%0d err=%0b to=%0b st=%0d, want all 0",
               d_wr_en, d_addr, d_char, d_err, d_timeout, d_state);
    end
    chk_t("reset_to", 1'b0, 12'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic test_spaced_bytes();
    send_byte(8'd17);
    idle(2170);
    send_byte(8'd29);
    idle(2170);
    n_tests++;
    if (d_wr_en !== 1'b0 || d_state !== 2'd2) begin
      n_fail++;
      $display("FAIL spaced_pre: got we=%0b st=%0d, want we=0 st=2", d_wr_en, d_state);
    end
    send_byte(8'd50);
    n_tests++;
    if ({d_wr_en, d_addr, d_char, d_err} !== {1'b1, 12'd2337, 8'd50, 1'b0}) begin
      n_fail++;
      $display("FAIL spaced_write: got we=%0b addr=%0d char=%0d err=%0b, want we=1 addr=2337 char=50 err=0",
               d_wr_en, d_addr, d_char, d_err);
    end
    idle(1);
    n_tests++;
    if ({d_wr_en, d_addr, d_char} !== {1'b0, 12'd2337, 8'd50}) begin
      n_fail++;
      $display("FAIL spaced_hold: got we=%0b addr=%0d char=%0d, want we=0 addr=2337 char=50",
               d_wr_en, d_addr, d_char);
    end
    do_reset();
  endtask

  task automatic test_valid_cmds();
    send_byte(8'd79); idle(1);
    send_byte(8'd0);  idle(1);
    send_byte(8'd57);
    chk_t("corner_79_0", 1'b1, 12'd79, 8'd57, 1'b0, 1'b0);
    idle(1);
    send_byte(8'd0);
    chk_t("hold_after_write", 1'b0, 12'd79, 8'd57, 1'b0, 1'b0);
    send_byte(8'd0);
    send_byte(8'd65);
    chk_t("origin_0_0", 1'b1, 12'd0, 8'd65, 1'b0, 1'b0);
    idle(1);
    send_byte(8'd79); send_byte(8'd29); send_byte(8'd126);
    chk_t("max_addr", 1'b1, 12'd2399, 8'd126, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_range_err();
    send_byte(8'd80); send_byte(8'd5); send_byte(8'd65);
    chk_t("col_80_err", 1'b0, 12'd2399, 8'd126, 1'b1, 1'b0);
    idle(1);
    chk_t("err_one_cycle", 1'b0, 12'd2399, 8'd126, 1'b0, 1'b0);
    send_byte(8'd3); send_byte(8'd30); send_byte(8'd65);
    chk_t("row_30_err", 1'b0, 12'd2399, 8'd126, 1'b1, 1'b0);
    send_byte(8'd255); send_byte(8'd0); send_byte(8'd65);
    chk_t("col_255_err", 1'b0, 12'd2399, 8'd126, 1'b1, 1'b0);
    send_byte(8'd1); send_byte(8'd1); send_byte(8'd66);
    chk_t("after_err_81", 1'b1, 12'd81, 8'd66, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_timeout();
    send_byte(8'd10);
    send_byte(8'd2);
    idle(99);
    n_tests++;
    if (t_timeout !== 1'b0 || t_state !== 2'd2) begin
      n_fail++;
      $display("FAIL to_early: got to=%0b st=%0d, want to=0 st=2", t_timeout, t_state);
    end
    idle(1);
    chk_t("to_pulse", 1'b0, 12'd81, 8'd66, 1'b0, 1'b1);
    n_tests++;
    if (t_state !== 2'd0) begin
      n_fail++;
      $display("FAIL to_state: got st=%0d, want 0", t_state);
    end
    idle(1);
    chk_t("to_one_cycle", 1'b0, 12'd81, 8'd66, 1'b0, 1'b0);
    send_byte(8'd4); send_byte(8'd3); send_byte(8'd88);
    chk_t("after_to_244", 1'b1, 12'd244, 8'd88, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [6] = '{8'd7, 8'd1, 8'd33, 8'd5, 8'd2, 8'd34};
    for (int i = 0; i < 6; i++) begin
      wr = 1'b1; data = bytes[i];
      @(negedge clk);
      if (i == 1) chk_t("b2b_before", 1'b0, 12'd244, 8'd88, 1'b0, 1'b0);
      if (i == 2) chk_t("b2b_first_87", 1'b1, 12'd87, 8'd33, 1'b0, 1'b0);
      if (i == 3) chk_t("b2b_gap", 1'b0, 12'd87, 8'd33, 1'b0, 1'b0);
    end
    wr = 1'b0;
    chk_t("b2b_second_165", 1'b1, 12'd165, 8'd34, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_expiry_collision();
    send_byte(8'd9);
    idle(99);
    send_byte(8'd2);
    chk_t("collide_no_to", 1'b0, 12'd165, 8'd34, 1'b0, 1'b0);
    n_tests++;
    if (t_state !== 2'd2) begin
      n_fail++;
      $display("FAIL collide_state: got st=%0d, want 2", t_state);
    end
    idle(1);
    chk_t("collide_after", 1'b0, 12'd165, 8'd34, 1'b0, 1'b0);
    send_byte(8'd40);
    chk_t("collide_write_169", 1'b1, 12'd169, 8'd40, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic test_reset_mid_cmd();
    send_byte(8'd5);
    send_byte(8'd5);
    rst = 1'b1; wr = 1'b1; data = 8'd9;
    @(negedge clk);
    rst = 1'b0; wr = 1'b0;
    chk_t("mid_reset_outputs", 1'b0, 12'd0, 8'd0, 1'b0, 1'b0);
    n_tests++;
    if (t_state !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset_state: got st=%0d, want 0", t_state);
    end
    send_byte(8'd2); send_byte(8'd0); send_byte(8'd49);
    chk_t("mid_reset_resync", 1'b1, 12'd2, 8'd49, 1'b0, 1'b0);
    idle(1);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_spaced_bytes();
    test_valid_cmds();
    test_range_err();
    test_timeout();
    test_back_to_back();
    test_expiry_collision();
    test_reset_mid_cmd();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
